gmt_cmd_sched: RTL and testbench

GMT_CMD_SCHED -- requirements
Module: gmt_cmd_sched

---
 rtl/vpu_pkg.sv | 51 +++++
 rtl/cmd_fifo.sv | 58 +++++
 rtl/gmt_cmd_sched.sv | 138 +++++++++++++
 tb/tb_gmt_cmd_sched.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vpu_pkg.sv
`default_nettype none
// vpu_pkg: geometry op codes, broadcast eligibility, command record and
// scheduler state encoding shared by the VPU command path.  rev 1.0
package vpu_pkg;

  localparam logic [3:0] GMT_OP_NOP     = 4'h0;
  localparam logic [3:0] GMT_OP_INIT    = 4'h1;
  localparam logic [3:0] GMT_OP_STORE   = 4'h2;
  localparam logic [3:0] GMT_OP_XLATE   = 4'h3;
  localparam logic [3:0] GMT_OP_ROTATE  = 4'h4;
  localparam logic [3:0] GMT_OP_SCALE   = 4'h5;
  localparam logic [3:0] GMT_OP_SHEAR   = 4'h6;
  localparam logic [3:0] GMT_OP_MIRROR  = 4'h7;
  localparam logic [3:0] GMT_OP_PROJECT = 4'h8;
  localparam logic [3:0] GMT_OP_LIGHT   = 4'h9;
  localparam logic [3:0] GMT_OP_COLOR   = 4'hA;
  localparam logic [3:0] GMT_OP_QUERY   = 4'hB;
  localparam logic [3:0] GMT_OP_DELETE  = 4'hC;
  localparam logic [3:0] GMT_OP_HALT    = 4'hF;

  // One bit per op code; set where cmd_all fans the op out over all objects.
  localparam logic [15:0] GMT_BCAST_OPS =
      (16'd1 << GMT_OP_XLATE)   | (16'd1 << GMT_OP_ROTATE) |
      (16'd1 << GMT_OP_SCALE)   | (16'd1 << GMT_OP_SHEAR)  |
      (16'd1 << GMT_OP_MIRROR)  | (16'd1 << GMT_OP_PROJECT) |
      (16'd1 << GMT_OP_LIGHT)   | (16'd1 << GMT_OP_COLOR)  |
      (16'd1 << GMT_OP_DELETE);

  localparam int CMD_W = 30;

  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  code;
    logic [4:0]  obj;
    logic [15:0] arg;
    logic        bcast_req;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_NEXT  = 2'd3
  } sched_state_e;

  function automatic logic is_bcast_op(input logic [3:0] op);
    return GMT_BCAST_OPS[op];
  endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_fifo.sv
`default_nettype none
// cmd_fifo: synchronous first-word-fall-through command queue, power-of-two
// depth, pushes while full are dropped.  rev 1.0
module cmd_fifo #(
  parameter int WIDTH = 30,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/gmt_cmd_sched.sv
`default_nettype none
// gmt_cmd_sched: queues CPU geometry commands and sequences them, singly or per
// stored object, onto the matrix unit with a busy watchdog.  rev 1.0
module gmt_cmd_sched
  import vpu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_vld,
  output logic        cmd_rdy,
  input  logic [3:0]  cmd_op,
  input  logic [3:0]  cmd_code,
  input  logic [4:0]  cmd_obj,
  input  logic [15:0] cmd_arg,
  input  logic        cmd_all,
  output logic        mu_go,
  output logic [3:0]  mu_op,
  output logic [3:0]  mu_code,
  output logic [4:0]  mu_obj,
  output logic [15:0] mu_arg,
  input  logic        mu_busy,
  input  logic [4:0]  lst_obj,
  input  logic        lst_obj_vld,
  output logic        sched_busy,
  output logic        done,
  output logic        err
);

  localparam int             WDW     = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  cmd_t           push_cmd;
  cmd_t           head;
  logic           fifo_full;
  logic           fifo_empty;
  logic           pop;
  sched_state_e   state;
  logic           bcast;
  logic           head_bcast;
  logic [4:0]     snap_obj;
  logic [WDW-1:0] wdog;

  assign push_cmd   = '{op: cmd_op, code: cmd_code, obj: cmd_obj,
                        arg: cmd_arg, bcast_req: cmd_all};
  assign cmd_rdy    = !fifo_full;
  assign pop        = (state == ST_IDLE) && !fifo_empty;
  assign head_bcast = head.bcast_req && is_bcast_op(head.op);
  assign sched_busy = !fifo_empty || (state != ST_IDLE);

  cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (cmd_vld),
    .push_data (push_cmd),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // mu_op/code/arg double as the issue registers and mu_obj as the object
  // counter, so they hold steady from ISSUE until the unit is released.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      mu_go    <= 1'b0;
      mu_op    <= '0;
      mu_code  <= '0;
      mu_obj   <= '0;
      mu_arg   <= '0;
      bcast    <= 1'b0;
      snap_obj <= '0;
      wdog     <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      mu_go <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            mu_op    <= head.op;
            mu_code  <= head.code;
            mu_arg   <= head.arg;
            bcast    <= head_bcast;
            snap_obj <= lst_obj;
            if (head_bcast) begin
              mu_obj <= '0;
              if (lst_obj_vld) state <= ST_ISSUE;
              else             done  <= 1'b1;
            end else begin
              mu_obj <= head.obj;
              state  <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          mu_go <= 1'b1;
          wdog  <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // The go cycle itself is never taken as a release: the unit has
          // not yet had an edge to raise busy.
          if (mu_busy) begin
            if (wdog == WD_LAST) begin
              err   <= 1'b1;
              state <= ST_IDLE;
            end else begin
              wdog <= wdog + 1'b1;
            end
          end else if (!mu_go) begin
            state <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (bcast && (mu_obj != snap_obj)) begin
            mu_obj <= mu_obj + 5'd1;
            state  <= ST_ISSUE;
          end else begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gmt_cmd_sched.sv
`default_nettype none
// tb_gmt_cmd_sched: directed and randomized checks of the command scheduler
// against a queue-based model of expected matrix-unit issues.
module tb_gmt_cmd_sched;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_vld = 1'b0;
  logic [3:0]  cmd_op = '0;
  logic [3:0]  cmd_code = '0;
  logic [4:0]  cmd_obj = '0;
  logic [15:0] cmd_arg = '0;
  logic        cmd_all = 1'b0;
  logic        mu_busy = 1'b0;
  logic [4:0]  lst_obj = '0;
  logic        lst_obj_vld = 1'b0;
  logic        cmd_rdy;
  logic        mu_go;
  logic [3:0]  mu_op;
  logic [3:0]  mu_code;
  logic [4:0]  mu_obj;
  logic [15:0] mu_arg;
  logic        sched_busy;
  logic        done;
  logic        err;

  gmt_cmd_sched #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .cmd_op(cmd_op), .cmd_code(cmd_code), .cmd_obj(cmd_obj), .cmd_arg(cmd_arg),
    .cmd_all(cmd_all), .mu_go(mu_go), .mu_op(mu_op), .mu_code(mu_code),
    .mu_obj(mu_obj), .mu_arg(mu_arg), .mu_busy(mu_busy), .lst_obj(lst_obj),
    .lst_obj_vld(lst_obj_vld), .sched_busy(sched_busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int go_cnt = 0, done_cnt = 0, err_cnt = 0, exp_done = 0;
  int last_go_cyc = -1, min_gap = 1000, err_cyc = -1;
  bit stuck = 1'b0;
  int busy_len = 0, busy_left = 0;
  logic [28:0] act_q[$];
  logic [28:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; then behave as the matrix unit and record what the DUT shows.
  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    mu_busy = stuck || (busy_left > 0);
    if (busy_left > 0) busy_left--;
    if (mu_go === 1'b1) begin
      act_q.push_back({mu_op, mu_code, mu_obj, mu_arg});
      if (last_go_cyc >= 0 && (cyc - last_go_cyc) < min_gap) min_gap = cyc - last_go_cyc;
      last_go_cyc = cyc;
      go_cnt++;
      busy_left = busy_len;
    end
    if (done === 1'b1) done_cnt++;
    if (err === 1'b1) begin
      err_cnt++;
      err_cyc = cyc;
    end
  endtask

  task automatic push(input logic [3:0] op, input logic [3:0] code, input logic [4:0] obj,
                      input logic [15:0] arg, input logic all);
    bit acc;
    int n = 0;
    cmd_vld = 1'b1; cmd_op = op; cmd_code = code; cmd_obj = obj; cmd_arg = arg; cmd_all = all;
    do begin
      acc = (cmd_rdy === 1'b1);
      cycle();
      n++;
    end while (!acc && n < 200);
    cmd_vld = 1'b0;
    if (!acc) chk("push_accept", 64'(acc), 64'd1);
  endtask

  // Reference: what the matrix unit should see for one command.
  task automatic model(input logic [3:0] op, input logic [3:0] code, input logic [4:0] obj,
                       input logic [15:0] arg, input logic all);
    bit fan_out = all && (op inside {4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hC});
    if (!fan_out) exp_q.push_back({op, code, obj, arg});
    else if (lst_obj_vld)
      for (int o = 0; o <= int'(lst_obj); o++) exp_q.push_back({op, code, 5'(o), arg});
    exp_done++;
  endtask

  task automatic send(input logic [3:0] op, input logic [3:0] code, input logic [4:0] obj,
                      input logic [15:0] arg, input logic all);
    model(op, code, obj, arg, all);
    push(op, code, obj, arg, all);
  endtask

  task automatic drain();
    int n = 0;
    while (sched_busy !== 1'b0 && n < 1000) begin
      cycle();
      n++;
    end
    if (n >= 1000) chk("drain_timeout", 64'(n), 64'd0);
    cycle();
    cycle();
  endtask

  task automatic cmp_issues(input string tag);
    chk({tag, "_issues"}, 64'(act_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
      chk({tag, "_issue"}, 64'(act_q[i]), 64'(exp_q[i]));
    chk({tag, "_done"}, 64'(done_cnt), 64'(exp_done));
    act_q.delete();
    exp_q.delete();
    done_cnt = 0;
    exp_done = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rdy"}, 64'(cmd_rdy), 64'd1);
    chk({tag, "_go"}, 64'(mu_go), 64'd0);
    chk({tag, "_mu"}, 64'({mu_op, mu_code, mu_obj, mu_arg}), 64'd0);
    chk({tag, "_sbusy"}, 64'(sched_busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
  endtask

  initial begin
    int c0, g1, e0, d0, n;

    // Reset
    rst_n = 1'b0;
    cycle(); cycle();
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    cycle();

    // Single command: latency, fields, one go, one done
    busy_len = 4;
    send(4'h3, 4'h1, 5'd5, 16'd10, 1'b0);
    cycle();
    chk("lat_n1_go", 64'(mu_go), 64'd0);
    cycle();
    chk("lat_n2_go", 64'(mu_go), 64'd1);
    chk("single_obj", 64'(mu_obj), 64'd5);
    chk("single_arg", 64'(mu_arg), 64'd10);
    drain();
    cmp_issues("single");

    // Broadcast over objects 0..2; lst_obj moves after the first issue
    lst_obj = 5'd2; lst_obj_vld = 1'b1; busy_len = 2;
    send(4'h4, 4'h2, 5'd17, 16'hBEEF, 1'b1);
    n = 0;
    while (act_q.size() < 1 && n < 50) begin cycle(); n++; end
    lst_obj = 5'd7;
    while (act_q.size() < 3 && n < 100) begin cycle(); n++; end
    chk("bc_no_early_done", 64'(done_cnt), 64'd0);
    drain();
    cmp_issues("bcast");

    // Back-to-back issue spacing with an instant-release matrix unit
    lst_obj = 5'd3; busy_len = 0; min_gap = 1000; last_go_cyc = -1;
    send(4'hC, 4'h0, 5'd0, 16'h0001, 1'b1);
    drain();
    chk("bc_gap_ge3", 64'(min_gap >= 3), 64'd1);
    cmp_issues("bcast_fast");

    // Broadcast with nothing stored; cmd_all ignored for op 0x2
    lst_obj_vld = 1'b0;
    send(4'h5, 4'h3, 5'd1, 16'h0002, 1'b1);
    cycle();
    chk("empty_bc_done", 64'(done), 64'd1);
    chk("empty_bc_sbusy", 64'(sched_busy), 64'd0);
    send(4'h2, 4'h4, 5'd9, 16'h1234, 1'b1);
    drain();
    cmp_issues("empty_bc");

    // Fill the FIFO behind a long-running command
    busy_len = 6;
    for (int i = 0; i < 5; i++) send(4'h6, 4'(i), 5'(i + 1), 16'(100 + i), 1'b0);
    chk("full_rdy", 64'(cmd_rdy), 64'd0);
    c0 = cyc;
    send(4'h7, 4'h9, 5'd30, 16'hFFFF, 1'b0);
    chk("full_held", 64'((cyc - c0) > 1), 64'd1);
    drain();
    cmp_issues("full");
    chk("no_err_yet", 64'(err_cnt), 64'd0);

    // Watchdog: busy stuck, abort after TIMEOUT cycles, next command runs
    busy_len = 0; stuck = 1'b1;
    exp_q.push_back({4'h3, 4'h1, 5'd1, 16'h0005});
    push(4'h3, 4'h1, 5'd1, 16'h0005, 1'b0);
    send(4'h6, 4'h2, 5'd2, 16'h0006, 1'b0);
    n = 0;
    while (err_cnt == 0 && n < 100) begin cycle(); n++; end
    stuck = 1'b0;
    g1 = last_go_cyc;
    chk("to_latency", 64'(err_cyc - g1), 64'(TIMEOUT));
    drain();
    chk("to_err_once", 64'(err_cnt), 64'd1);
    cmp_issues("timeout");

    // Reset during the WAIT of object 1 of a broadcast, second command queued
    lst_obj = 5'd3; lst_obj_vld = 1'b1; busy_len = 4;
    push(4'h7, 4'h5, 5'd0, 16'h0AAA, 1'b1);
    push(4'h1, 4'h6, 5'd4, 16'h0BBB, 1'b0);
    n = 0;
    while (act_q.size() < 2 && n < 100) begin cycle(); n++; end
    cycle();
    rst_n = 1'b0;
    cycle();
    chk_reset_outputs("midrst");
    rst_n = 1'b1; busy_left = 0;
    e0 = err_cnt; d0 = done_cnt; c0 = act_q.size();
    repeat (20) cycle();
    chk("midrst_no_done", 64'(done_cnt), 64'(d0));
    chk("midrst_no_err", 64'(err_cnt), 64'(e0));
    chk("midrst_no_go", 64'(act_q.size()), 64'(c0));
    act_q.delete(); done_cnt = 0;

    // Randomized rounds
    for (int r = 0; r < 8; r++) begin
      lst_obj = 5'($urandom_range(0, 4));
      lst_obj_vld = 1'($urandom_range(0, 1));
      busy_len = $urandom_range(0, 5);
      n = $urandom_range(1, 5);
      for (int k = 0; k < n; k++) begin
        send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)),
             16'($urandom), 1'($urandom_range(0, 1)));
        repeat ($urandom_range(0, 2)) cycle();
      end
      drain();
      cmp_issues("rnd");
    end
    chk("rnd_no_err", 64'(err_cnt), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
